// File: rtl/bruteforce_scheduler.sv
// Controller for a bank of BruteForce candidate generators: configures the engines,
// runs them in lockstep, watches their candidates against a target and stops the bank.
module bruteforce_scheduler #(
    parameter int             NUM_ENGINES = 4,
    parameter int             PW_WIDTH    = 128,
    parameter logic [7:0]     FIRST_CHAR  = 8'h61
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic                            abort,
    input  logic [PW_WIDTH-1:0]             target,
    input  logic [7:0]                      maxLength,
    input  logic [31:0]                     maxCycles,
    output logic [NUM_ENGINES-1:0]          engineEnable,
    output logic                            engineClear,
    output logic [8*NUM_ENGINES-1:0]        startingPosition,
    output logic [2:0]                      increment,
    input  logic [PW_WIDTH*NUM_ENGINES-1:0] enginePassword,
    input  logic [8*NUM_ENGINES-1:0]        engineWordLength,
    output logic                            busy,
    output logic                            found,
    output logic                            done,
    output logic                            timeout,
    output logic [2:0]                      foundEngine,
    output logic [PW_WIDTH-1:0]             foundPassword,
    output logic [31:0]                     cycleCount
);

    typedef enum logic [2:0] {IDLE, LOAD, RUN, FOUND, EXHAUSTED} state_t;

    state_t                                 state;
    logic [PW_WIDTH-1:0]                    target_q;
    logic [7:0]                             max_length_q;
    logic [31:0]                            max_cycles_q;
    logic [NUM_ENGINES-1:0]                 match_q;
    logic                                   match_vld;
    logic [NUM_ENGINES-1:0][PW_WIDTH-1:0]   pw_q;

    logic [NUM_ENGINES-1:0]                 match_now;
    logic                                   any_match;
    logic [2:0]                             hit_idx;
    logic [PW_WIDTH-1:0]                    hit_pw;
    logic                                   exhausted;
    logic                                   timed_out;
    logic [31:0]                            cycle_next;

    for (genvar g = 0; g < NUM_ENGINES; g++) begin : g_eng
        assign startingPosition[g*8 +: 8] = 8'(FIRST_CHAR + g);
        assign match_now[g] = (enginePassword[g*PW_WIDTH +: PW_WIDTH] == target_q);
    end

    assign increment = 3'(NUM_ENGINES);

    // Descending scan so the lowest matching engine wins.
    always_comb begin
        hit_idx   = 3'd0;
        hit_pw    = '0;
        exhausted = 1'b0;
        for (int i = NUM_ENGINES - 1; i >= 0; i--) begin
            if (match_q[i]) begin
                hit_idx = 3'(i);
                hit_pw  = pw_q[i];
            end
        end
        for (int i = 0; i < NUM_ENGINES; i++) begin
            if (engineWordLength[i*8 +: 8] > max_length_q) exhausted = 1'b1;
        end
    end

    // match_vld masks compare results registered outside RUN (notably the LOAD cycle).
    assign any_match  = match_vld && (|match_q);
    assign timed_out  = (max_cycles_q != 32'd0) && (cycleCount == max_cycles_q - 32'd1);
    assign cycle_next = (cycleCount == 32'hFFFF_FFFF) ? cycleCount : cycleCount + 32'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            target_q      <= '0;
            max_length_q  <= '0;
            max_cycles_q  <= '0;
            match_q       <= '0;
            match_vld     <= 1'b0;
            pw_q          <= '0;
            engineEnable  <= '0;
            engineClear   <= 1'b0;
            busy          <= 1'b0;
            found         <= 1'b0;
            done          <= 1'b0;
            timeout       <= 1'b0;
            foundEngine   <= '0;
            foundPassword <= '0;
            cycleCount    <= '0;
        end else begin
            match_q     <= match_now;
            match_vld   <= (state == RUN);
            pw_q        <= enginePassword;
            engineClear <= 1'b0;
            case (state)
                IDLE, FOUND, EXHAUSTED: begin
                    if (start) begin
                        target_q      <= target;
                        max_length_q  <= maxLength;
                        max_cycles_q  <= maxCycles;
                        found         <= 1'b0;
                        done          <= 1'b0;
                        timeout       <= 1'b0;
                        foundEngine   <= '0;
                        foundPassword <= '0;
                        cycleCount    <= '0;
                        engineClear   <= 1'b1;
                        busy          <= 1'b1;
                        state         <= LOAD;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        engineEnable <= '1;
                        state        <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        engineEnable <= '0;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end else begin
                        cycleCount <= cycle_next;
                        if (any_match) begin
                            found         <= 1'b1;
                            done          <= 1'b1;
                            foundEngine   <= hit_idx;
                            foundPassword <= hit_pw;
                            engineEnable  <= '0;
                            busy          <= 1'b0;
                            state         <= FOUND;
                        end else if (exhausted || timed_out) begin
                            done         <= 1'b1;
                            timeout      <= !exhausted;
                            engineEnable <= '0;
                            busy         <= 1'b0;
                            state        <= EXHAUSTED;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bruteforce_scheduler.sv
// Directed bench for bruteforce_scheduler; results are scoreboarded whenever busy falls.
module tb_bruteforce_scheduler;

    localparam int N  = 4;
    localparam int PW = 128;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 start = 1'b0;
    logic                 abort = 1'b0;
    logic [PW-1:0]        target = '0;
    logic [7:0]           maxLength = 8'd16;
    logic [31:0]          maxCycles = '0;
    logic [N-1:0]         engineEnable;
    logic                 engineClear;
    logic [8*N-1:0]       startingPosition;
    logic [2:0]           increment;
    logic [N-1:0][PW-1:0] epw;
    logic [N-1:0][7:0]    ewl;
    logic                 busy, found, done, timeout;
    logic [2:0]           foundEngine;
    logic [PW-1:0]        foundPassword;
    logic [31:0]          cycleCount;

    bruteforce_scheduler #(.NUM_ENGINES(N), .PW_WIDTH(PW), .FIRST_CHAR(8'h61)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .target(target),
        .maxLength(maxLength), .maxCycles(maxCycles), .engineEnable(engineEnable),
        .engineClear(engineClear), .startingPosition(startingPosition), .increment(increment),
        .enginePassword(epw), .engineWordLength(ewl), .busy(busy), .found(found),
        .done(done), .timeout(timeout), .foundEngine(foundEngine),
        .foundPassword(foundPassword), .cycleCount(cycleCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          found;
        logic          done;
        logic          timeout;
        logic [2:0]    eng;
        logic [PW-1:0] pw;
        logic [31:0]   cyc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    logic prev_busy = 1'b0;

    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push(input logic f, input logic d, input logic t, input logic [2:0] e,
                        input logic [PW-1:0] p, input logic [31:0] c);
        exp_t x;
        x.found = f; x.done = d; x.timeout = t; x.eng = e; x.pw = p; x.cyc = c;
        exp_q.push_back(x);
    endtask

    // Monitor: a search has just ended whenever busy falls.
    always @(negedge clk) begin
        if (prev_busy === 1'b1 && busy === 1'b0) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_end actual=end required=none");
            end else begin
                exp_t x;
                x = exp_q.pop_front();
                chk("res_found",   PW'(found),       PW'(x.found));
                chk("res_done",    PW'(done),        PW'(x.done));
                chk("res_timeout", PW'(timeout),     PW'(x.timeout));
                chk("res_engine",  PW'(foundEngine), PW'(x.eng));
                chk("res_pw",      foundPassword,    x.pw);
                chk("res_cycles",  PW'(cycleCount),  PW'(x.cyc));
                chk("res_enable",  PW'(engineEnable), '0);
            end
        end
        prev_busy <= busy;
    end

    // Issue a start and check the LOAD cycle and the first RUN cycle.
    task automatic do_start(input logic [PW-1:0] t, input logic [7:0] ml, input logic [31:0] mc);
        @(negedge clk);
        target = t; maxLength = ml; maxCycles = mc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("load_clear",  PW'(engineClear),  PW'(1));
        chk("load_enable", PW'(engineEnable), '0);
        chk("load_busy",   PW'(busy),         PW'(1));
        chk("load_found",  PW'(found),        '0);
        chk("load_done",   PW'(done),         '0);
        @(negedge clk);
        chk("run_clear",   PW'(engineClear),  '0);
        chk("run_enable",  PW'(engineEnable), PW'(4'hF));
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            total++; bad++;
            $display("FAIL %s_timeout actual=busy required=idle", name);
        end
        @(negedge clk);
    endtask

    initial begin
        epw = '0;
        ewl = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_busy",   PW'(busy),             '0);
        chk("rst_enable", PW'(engineEnable),     '0);
        chk("rst_found",  PW'(found),            '0);
        chk("rst_done",   PW'(done),             '0);
        chk("rst_cycles", PW'(cycleCount),       '0);
        chk("start_pos",  PW'(startingPosition), PW'(32'h6463_6261));
        chk("increment",  PW'(increment),        PW'(3'd4));

        // Engine 3 shows "d" from the start; LOAD-cycle compare is masked, so 2 RUN cycles.
        epw = '{128'h64, 128'h63, 128'h62, 128'h61};
        ewl = '{8'd1, 8'd1, 8'd1, 8'd1};
        push(1, 1, 0, 3'd3, 128'h64, 32'd2);
        do_start(128'h64, 8'd16, 32'd0);
        wait_idle("imm_match");

        // Engines 1 and 2 both match; started from FOUND.
        epw = '{128'h7a7a, 128'h41, 128'h41, 128'h7a79};
        push(1, 1, 0, 3'd1, 128'h41, 32'd2);
        do_start(128'h41, 8'd16, 32'd0);
        wait_idle("simul_match");

        // Exhaustion on the first RUN cycle.
        epw = '{128'h61, 128'h62, 128'h63, 128'h64};
        ewl = '{8'd1, 8'd2, 8'd1, 8'd1};
        push(0, 1, 0, 3'd0, '0, 32'd1);
        do_start(128'h5a5a, 8'd1, 32'd0);
        wait_idle("exhaust");

        // Timeout after 10 RUN cycles; a start mid-run with different limits is ignored.
        ewl = '{8'd1, 8'd1, 8'd1, 8'd1};
        push(0, 1, 1, 3'd0, '0, 32'd10);
        do_start(128'h5a5a, 8'd16, 32'd10);
        maxCycles = 32'd20; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("timeout");

        // Abort once cycleCount reaches 5.
        push(0, 0, 0, 3'd0, '0, 32'd5);
        do_start(128'h5a5a, 8'd16, 32'd0);
        begin
            int n;
            n = 0;
            while (cycleCount != 32'd5 && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_idle("abort");

        // Reset in the middle of a run clears everything.
        do_start(128'h5a5a, 8'd16, 32'd0);
        repeat (3) @(negedge clk);
        push(0, 0, 0, 3'd0, '0, 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst2_busy", PW'(busy), '0);
        repeat (2) @(negedge clk);
        chk("queue_empty", PW'(exp_q.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
